// File: rtl/branch_rs.sv
// Branch reservation station: buffers dispatched branch/jump ops, captures CDB results
// and issues the oldest ready op each cycle on a registered port to the branch unit.
module branch_rs #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             disp_valid,
    input  logic [3:0]       disp_op,
    input  logic [31:0]      disp_pc,
    input  logic [31:0]      disp_offset,
    input  logic [TAG_W-1:0] disp_dest,
    input  logic             disp_qj_wait,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic [31:0]      disp_vj,
    input  logic             disp_qk_wait,
    input  logic [TAG_W-1:0] disp_qk,
    input  logic [31:0]      disp_vk,
    output logic             rs_full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_val,
    input  logic             flush,
    output logic [3:0]       iss_op,
    output logic [31:0]      iss_srca,
    output logic [31:0]      iss_srcb,
    output logic [31:0]      iss_pc,
    output logic [31:0]      iss_offset,
    output logic [TAG_W-1:0] iss_dest
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] qjw_q, qkw_q;
    logic [3:0]       op_q     [DEPTH];
    logic [31:0]      pc_q     [DEPTH];
    logic [31:0]      offset_q [DEPTH];
    logic [TAG_W-1:0] dest_q   [DEPTH];
    logic [TAG_W-1:0] qj_q     [DEPTH];
    logic [TAG_W-1:0] qk_q     [DEPTH];
    logic [31:0]      vj_q     [DEPTH];
    logic [31:0]      vk_q     [DEPTH];
    // age_q[i][j] = 1 when entry i was dispatched before entry j
    logic [DEPTH-1:0] age_q    [DEPTH];

    logic [DEPTH-1:0] ready, older_rdy, sel_oh;
    logic [DEPTH-1:0] wake_j, wake_k;
    logic [IDX_W-1:0] sel_idx, free_idx;
    logic             sel_any, free_found, disp_fire, byp_j, byp_k;

    assign rs_full   = &valid_q;
    assign disp_fire = disp_valid & ~rs_full & ~flush;
    assign byp_j     = cdb_valid & disp_qj_wait & (disp_qj == cdb_tag);
    assign byp_k     = cdb_valid & disp_qk_wait & (disp_qk == cdb_tag);

    always_comb begin
        ready      = valid_q & ~qjw_q & ~qkw_q;
        older_rdy  = '0;
        sel_idx    = '0;
        sel_any    = 1'b0;
        free_idx   = '0;
        free_found = 1'b0;
        wake_j     = '0;
        wake_k     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (ready[j] && age_q[j][i]) begin
                    older_rdy[i] = 1'b1;
                end
            end
        end
        sel_oh = ready & ~older_rdy;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                sel_idx = IDX_W'(i);
                sel_any = 1'b1;
            end
            if (!valid_q[i] && !free_found) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
            wake_j[i] = cdb_valid & valid_q[i] & qjw_q[i] & (qj_q[i] == cdb_tag);
            wake_k[i] = cdb_valid & valid_q[i] & qkw_q[i] & (qk_q[i] == cdb_tag);
        end
        valid_d = valid_q & ~sel_oh;
        if (disp_fire) begin
            valid_d[free_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            qjw_q      <= '0;
            qkw_q      <= '0;
            iss_op     <= '0;
            iss_srca   <= '0;
            iss_srcb   <= '0;
            iss_pc     <= '0;
            iss_offset <= '0;
            iss_dest   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                op_q[i]     <= '0;
                pc_q[i]     <= '0;
                offset_q[i] <= '0;
                dest_q[i]   <= '0;
                qj_q[i]     <= '0;
                qk_q[i]     <= '0;
                vj_q[i]     <= '0;
                vk_q[i]     <= '0;
                age_q[i]    <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            iss_op  <= '0;
        end else begin
            valid_q <= valid_d;
            if (sel_any) begin
                iss_op     <= op_q[sel_idx];
                iss_srca   <= vj_q[sel_idx];
                iss_srcb   <= vk_q[sel_idx];
                iss_pc     <= pc_q[sel_idx];
                iss_offset <= offset_q[sel_idx];
                iss_dest   <= dest_q[sel_idx];
            end else begin
                iss_op <= '0;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wake_j[i]) begin
                    vj_q[i]  <= cdb_val;
                    qjw_q[i] <= 1'b0;
                end
                if (wake_k[i]) begin
                    vk_q[i]  <= cdb_val;
                    qkw_q[i] <= 1'b0;
                end
            end
            if (disp_fire) begin
                op_q[free_idx]     <= disp_op;
                pc_q[free_idx]     <= disp_pc;
                offset_q[free_idx] <= disp_offset;
                dest_q[free_idx]   <= disp_dest;
                qj_q[free_idx]     <= disp_qj;
                qk_q[free_idx]     <= disp_qk;
                qjw_q[free_idx]    <= disp_qj_wait & ~byp_j;
                qkw_q[free_idx]    <= disp_qk_wait & ~byp_k;
                vj_q[free_idx]     <= byp_j ? cdb_val : disp_vj;
                vk_q[free_idx]     <= byp_k ? cdb_val : disp_vk;
                // New entry is younger than every other entry
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    age_q[free_idx][j] <= 1'b0;
                    age_q[j][free_idx] <= (IDX_W'(j) != free_idx);
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_rs.sv
// Self-checking bench for branch_rs: directed scenarios plus random traffic, all checked
// against an age-ordered queue model of the station.
module tb_branch_rs;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             disp_valid;
    logic [3:0]       disp_op;
    logic [31:0]      disp_pc, disp_offset, disp_vj, disp_vk;
    logic [TAG_W-1:0] disp_dest, disp_qj, disp_qk;
    logic             disp_qj_wait, disp_qk_wait;
    logic             rs_full;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_val;
    logic             flush;
    logic [3:0]       iss_op;
    logic [31:0]      iss_srca, iss_srcb, iss_pc, iss_offset;
    logic [TAG_W-1:0] iss_dest;

    always #5 clk = ~clk;

    branch_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_pc(disp_pc),
        .disp_offset(disp_offset), .disp_dest(disp_dest),
        .disp_qj_wait(disp_qj_wait), .disp_qj(disp_qj), .disp_vj(disp_vj),
        .disp_qk_wait(disp_qk_wait), .disp_qk(disp_qk), .disp_vk(disp_vk),
        .rs_full(rs_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .flush(flush),
        .iss_op(iss_op), .iss_srca(iss_srca), .iss_srcb(iss_srcb),
        .iss_pc(iss_pc), .iss_offset(iss_offset), .iss_dest(iss_dest)
    );

    // Model: queue kept in dispatch order, so the oldest ready op is the first ready one.
    typedef struct packed {
        logic [3:0]       op;
        logic [31:0]      pc;
        logic [31:0]      off;
        logic [TAG_W-1:0] dest;
        logic             jw;
        logic [TAG_W-1:0] qj;
        logic [31:0]      vj;
        logic             kw;
        logic [TAG_W-1:0] qk;
        logic [31:0]      vk;
    } ent_t;

    ent_t             mq[$];
    logic [3:0]       m_op;
    logic [31:0]      m_srca, m_srcb, m_pc, m_off;
    logic [TAG_W-1:0] m_dest;
    logic             m_full;
    int               checks = 0;
    int               errors = 0;

    task automatic model_reset();
        mq.delete();
        m_op = '0; m_srca = '0; m_srcb = '0; m_pc = '0; m_off = '0; m_dest = '0;
        m_full = 1'b0;
    endtask

    task automatic model_update();
        int   sel;
        bit   was_full;
        ent_t e;
        was_full = (mq.size() == DEPTH);
        sel = -1;
        if (flush) begin
            mq.delete();
            m_op = '0;
        end else begin
            for (int i = 0; i < mq.size(); i++)
                if (sel < 0 && !mq[i].jw && !mq[i].kw) sel = i;
            if (sel >= 0) begin
                m_op = mq[sel].op; m_srca = mq[sel].vj; m_srcb = mq[sel].vk;
                m_pc = mq[sel].pc; m_off = mq[sel].off; m_dest = mq[sel].dest;
                mq.delete(sel);
            end else begin
                m_op = '0;
            end
            if (cdb_valid) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].jw && mq[i].qj == cdb_tag) begin
                        mq[i].jw = 1'b0; mq[i].vj = cdb_val;
                    end
                    if (mq[i].kw && mq[i].qk == cdb_tag) begin
                        mq[i].kw = 1'b0; mq[i].vk = cdb_val;
                    end
                end
            end
            if (disp_valid && !was_full) begin
                e.op = disp_op; e.pc = disp_pc; e.off = disp_offset; e.dest = disp_dest;
                e.jw = disp_qj_wait; e.qj = disp_qj; e.vj = disp_vj;
                e.kw = disp_qk_wait; e.qk = disp_qk; e.vk = disp_vk;
                if (cdb_valid && e.jw && e.qj == cdb_tag) begin e.jw = 1'b0; e.vj = cdb_val; end
                if (cdb_valid && e.kw && e.qk == cdb_tag) begin e.kw = 1'b0; e.vk = cdb_val; end
                mq.push_back(e);
            end
        end
        m_full = (mq.size() == DEPTH);
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic set_disp(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] off,
                            input logic [TAG_W-1:0] dest, input logic jw,
                            input logic [TAG_W-1:0] qj, input logic [31:0] vj, input logic kw,
                            input logic [TAG_W-1:0] qk, input logic [31:0] vk);
        disp_valid = 1'b1; disp_op = op; disp_pc = pc; disp_offset = off; disp_dest = dest;
        disp_qj_wait = jw; disp_qj = qj; disp_vj = vj;
        disp_qk_wait = kw; disp_qk = qk; disp_vk = vk;
    endtask

    task automatic set_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_val = val;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
        disp_op = '0; disp_pc = '0; disp_offset = '0; disp_dest = '0;
        disp_qj_wait = 1'b0; disp_qj = '0; disp_vj = '0;
        disp_qk_wait = 1'b0; disp_qk = '0; disp_vk = '0;
        cdb_tag = '0; cdb_val = '0;
        model_reset();
        #12;
        checks++;
        if ({iss_op, iss_srca, iss_srcb, iss_pc, iss_offset, iss_dest, rs_full} !== '0) begin
            errors++;
            $display("FAIL reset: got op=%0h a=%h b=%h pc=%h off=%h dst=%0h full=%b want all 0",
                     iss_op, iss_srca, iss_srcb, iss_pc, iss_offset, iss_dest, rs_full);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        for (int s = 0; s < 3; s++) begin
            if (s == 0) set_disp(4'd1, 32'h100, 32'h20, 5'd3, 1'b0, '0, 32'd5, 1'b0, '0, 32'd5);
            tick();
            checks++;
            if ({iss_op, iss_srca, iss_srcb, iss_pc, iss_offset, iss_dest, rs_full} !==
                {m_op, m_srca, m_srcb, m_pc, m_off, m_dest, m_full}) begin
                errors++;
                $display("FAIL basic step %0d: got op=%0h a=%h b=%h dst=%0h full=%b want op=%0h a=%h b=%h dst=%0h full=%b",
                         s, iss_op, iss_srca, iss_srcb, iss_dest, rs_full,
                         m_op, m_srca, m_srcb, m_dest, m_full);
            end
            if (s == 1) begin
                checks++;
                if (iss_op !== 4'd1 || iss_srca !== 32'd5 || iss_srcb !== 32'd5 ||
                    iss_pc !== 32'h100 || iss_offset !== 32'h20 || iss_dest !== 5'd3) begin
                    errors++;
                    $display("FAIL basic_beq: got op=%0h a=%h b=%h pc=%h off=%h dst=%0h want 1/5/5/100/20/3",
                             iss_op, iss_srca, iss_srcb, iss_pc, iss_offset, iss_dest);
                end
            end
            if (s != 1) begin
                checks++;
                if (iss_op !== 4'd0) begin
                    errors++;
                    $display("FAIL basic_idle step %0d: got op=%0h want 0", s, iss_op);
                end
            end
        end
    endtask

    task automatic test_wakeup();
        for (int s = 0; s < 4; s++) begin
            if (s == 0) set_disp(4'd2, 32'h200, 32'h8, 5'd4, 1'b1, 5'd7, 32'h0, 1'b0, '0, 32'd3);
            if (s == 2) set_cdb(5'd7, 32'h9);
            tick();
            checks++;
            if ({iss_op, iss_srca, iss_srcb, iss_pc, iss_offset, iss_dest, rs_full} !==
                {m_op, m_srca, m_srcb, m_pc, m_off, m_dest, m_full}) begin
                errors++;
                $display("FAIL wakeup step %0d: got op=%0h a=%h b=%h dst=%0h full=%b want op=%0h a=%h b=%h dst=%0h full=%b",
                         s, iss_op, iss_srca, iss_srcb, iss_dest, rs_full,
                         m_op, m_srca, m_srcb, m_dest, m_full);
            end
            checks++;
            if ((s < 3 && iss_op !== 4'd0) ||
                (s == 3 && (iss_op !== 4'd2 || iss_srca !== 32'h9))) begin
                errors++;
                $display("FAIL wakeup_timing step %0d: got op=%0h a=%h", s, iss_op, iss_srca);
            end
        end
    endtask

    task automatic test_age();
        logic [3:0] want_op [10];
        want_op = '{4'd0, 4'd0, 4'd4, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd6, 4'd7};
        for (int s = 0; s < 10; s++) begin
            case (s)
                0: set_disp(4'd3, 32'h300, 32'h4, 5'd10, 1'b1, 5'd2, 32'h0, 1'b0, '0, 32'd1);
                1: set_disp(4'd4, 32'h304, 32'h4, 5'd11, 1'b0, '0, 32'h11, 1'b0, '0, 32'h12);
                3: set_cdb(5'd2, 32'h22);
                5: set_disp(4'd6, 32'h308, 32'h4, 5'd12, 1'b1, 5'd6, 32'h0, 1'b0, '0, 32'd2);
                6: set_disp(4'd7, 32'h30c, 32'h4, 5'd13, 1'b0, '0, 32'd9, 1'b1, 5'd6, 32'h0);
                7: set_cdb(5'd6, 32'h66);
                default: ;
            endcase
            tick();
            checks++;
            if ({iss_op, iss_srca, iss_srcb, iss_pc, iss_offset, iss_dest, rs_full} !==
                {m_op, m_srca, m_srcb, m_pc, m_off, m_dest, m_full}) begin
                errors++;
                $display("FAIL age step %0d: got op=%0h a=%h b=%h dst=%0h full=%b want op=%0h a=%h b=%h dst=%0h full=%b",
                         s, iss_op, iss_srca, iss_srcb, iss_dest, rs_full,
                         m_op, m_srca, m_srcb, m_dest, m_full);
            end
            checks++;
            if (iss_op !== want_op[s]) begin
                errors++;
                $display("FAIL age_order step %0d: got op=%0h want %0h", s, iss_op, want_op[s]);
            end
        end
    endtask

    task automatic test_bypass();
        for (int s = 0; s < 2; s++) begin
            if (s == 0) begin
                set_disp(4'd8, 32'h400, 32'h10, 5'd14, 1'b0, '0, 32'd1, 1'b1, 5'd4, 32'h0);
                set_cdb(5'd4, 32'hAB);
            end
            tick();
            checks++;
            if ({iss_op, iss_srca, iss_srcb, iss_pc, iss_offset, iss_dest, rs_full} !==
                {m_op, m_srca, m_srcb, m_pc, m_off, m_dest, m_full}) begin
                errors++;
                $display("FAIL bypass step %0d: got op=%0h a=%h b=%h dst=%0h want op=%0h a=%h b=%h dst=%0h",
                         s, iss_op, iss_srca, iss_srcb, iss_dest, m_op, m_srca, m_srcb, m_dest);
            end
            if (s == 1) begin
                checks++;
                if (iss_op !== 4'd8 || iss_srcb !== 32'hAB) begin
                    errors++;
                    $display("FAIL bypass_value: got op=%0h b=%h want 8/ab", iss_op, iss_srcb);
                end
            end
        end
    endtask

    task automatic test_full();
        for (int s = 0; s < 10; s++) begin
            if (s < 5)
                set_disp(4'd5, 32'h500 + 32'(s), 32'h4, 5'(s), 1'b1, 5'(10 + s), 32'h0,
                         1'b0, '0, 32'(s));
            if (s == 5) set_cdb(5'd11, 32'h55);
            if (s == 7) set_cdb(5'd14, 32'h77);
            if (s == 9) flush = 1'b1;
            tick();
            checks++;
            if ({iss_op, iss_srca, iss_srcb, iss_pc, iss_offset, iss_dest, rs_full} !==
                {m_op, m_srca, m_srcb, m_pc, m_off, m_dest, m_full}) begin
                errors++;
                $display("FAIL full step %0d: got op=%0h a=%h dst=%0h full=%b want op=%0h a=%h dst=%0h full=%b",
                         s, iss_op, iss_srca, iss_dest, rs_full, m_op, m_srca, m_dest, m_full);
            end
            if (s >= 3 && s <= 5) begin
                checks++;
                if (rs_full !== 1'b1) begin
                    errors++;
                    $display("FAIL full_flag step %0d: got rs_full=%b want 1", s, rs_full);
                end
            end
            if (s == 6) begin
                checks++;
                if (iss_op !== 4'd5 || iss_srca !== 32'h55 || iss_dest !== 5'd1 || rs_full !== 1'b0) begin
                    errors++;
                    $display("FAIL full_release: got op=%0h a=%h dst=%0h full=%b want 5/55/1/0",
                             iss_op, iss_srca, iss_dest, rs_full);
                end
            end
        end
    endtask

    task automatic test_flush();
        for (int s = 0; s < 7; s++) begin
            if (s < 3)
                set_disp(4'd9, 32'h600, 32'h4, 5'(20 + s), 1'b1, 5'(20 + s), 32'h0,
                         1'b0, '0, 32'd1);
            if (s == 3) begin
                set_disp(4'd10, 32'h700, 32'h4, 5'd30, 1'b0, '0, 32'd1, 1'b0, '0, 32'd2);
                flush = 1'b1;
            end
            if (s == 4) set_cdb(5'd20, 32'h1);
            if (s == 5) set_cdb(5'd21, 32'h2);
            tick();
            checks++;
            if ({iss_op, iss_srca, iss_srcb, iss_pc, iss_offset, iss_dest, rs_full} !==
                {m_op, m_srca, m_srcb, m_pc, m_off, m_dest, m_full}) begin
                errors++;
                $display("FAIL flush step %0d: got op=%0h dst=%0h full=%b want op=%0h dst=%0h full=%b",
                         s, iss_op, iss_dest, rs_full, m_op, m_dest, m_full);
            end
            if (s >= 3) begin
                checks++;
                if (iss_op !== 4'd0 || rs_full !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_empty step %0d: got op=%0h full=%b want 0/0", s, iss_op, rs_full);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 600; s++) begin
            if ($urandom_range(0, 1) == 1)
                set_disp(4'($urandom_range(1, 15)), $urandom, $urandom, 5'($urandom),
                         1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                         1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 1) == 1) set_cdb(5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 31) == 0) flush = 1'b1;
            tick();
            checks++;
            if ({iss_op, iss_srca, iss_srcb, iss_pc, iss_offset, iss_dest, rs_full} !==
                {m_op, m_srca, m_srcb, m_pc, m_off, m_dest, m_full}) begin
                errors++;
                $display("FAIL random step %0d: got op=%0h a=%h b=%h pc=%h off=%h dst=%0h full=%b want op=%0h a=%h b=%h pc=%h off=%h dst=%0h full=%b",
                         s, iss_op, iss_srca, iss_srcb, iss_pc, iss_offset, iss_dest, rs_full,
                         m_op, m_srca, m_srcb, m_pc, m_off, m_dest, m_full);
            end
        end
    endtask

    task automatic test_async_reset();
        flush = 1'b1;
        tick();
        for (int s = 0; s < 4; s++) begin
            set_disp(4'd11, 32'h800, 32'h4, 5'(s), 1'b1, 5'd25, 32'h0, 1'b0, '0, 32'd0);
            tick();
        end
        set_disp(4'd12, 32'h900, 32'h4, 5'd9, 1'b0, '0, 32'h3, 1'b0, '0, 32'h4);
        set_cdb(5'd25, 32'hCC);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({iss_op, iss_srca, iss_srcb, iss_pc, iss_offset, iss_dest, rs_full} !== '0) begin
            errors++;
            $display("FAIL async_reset: got op=%0h a=%h b=%h pc=%h off=%h dst=%0h full=%b want all 0",
                     iss_op, iss_srca, iss_srcb, iss_pc, iss_offset, iss_dest, rs_full);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            if (s == 0) set_cdb(5'd25, 32'hDD);
            tick();
            checks++;
            if ({iss_op, iss_srca, iss_srcb, iss_pc, iss_offset, iss_dest, rs_full} !==
                {m_op, m_srca, m_srcb, m_pc, m_off, m_dest, m_full}) begin
                errors++;
                $display("FAIL after_reset step %0d: got op=%0h a=%h full=%b want op=%0h a=%h full=%b",
                         s, iss_op, iss_srca, rs_full, m_op, m_srca, m_full);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_age();
        test_bypass();
        test_full();
        test_flush();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
